asp_request_packetizer: RTL and testbench

Converts software-issued requests from the Nios parallel output ports into packets for the ASP network. It sits directly downstream of the 8-bit address PIO and the 32-bit data PIO. A toggle of address bit 7 marks a new request; the block captures destination, type and payload, queues the packet in a small FIFO, and presents it on a valid/ready interface. FIFO state is exported on a status byte that software reads back through an input PIO.

---
 rtl/asp_request_packetizer.sv | 101 ++++++++++
 tb/tb_asp_request_packetizer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/asp_request_packetizer.sv
// rtl/asp_request_packetizer.sv - turns PIO toggle requests into queued ASP packets
//
// Purpose:
//   Watches the address PIO for a change on bit 7. Each change is one request.
//   On a request the block builds a 32-bit packet:
//     {1'b1, destination[3:0], type[2:0], payload[23:0]}
//   It queues the packet in a small FIFO and presents the head packet on a
//   valid/ready interface. FIFO state is exported on a status byte.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   addr_in    [7] request toggle, [6:4] packet type, [3:0] destination node
//   data_in    payload source; only [23:0] is used
//   pkt_data   head-of-queue packet; reads 0 while the queue is empty
//   pkt_valid  a packet is available on pkt_data
//   pkt_ready  downstream accepts the head packet
//   ovf_clear  pulse that clears the sticky overflow flag
//   status     {overflow, empty, full, count[4:0]}

module asp_request_packetizer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  input  logic        ovf_clear,
  output logic [7:0]  status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  logic          r_tog;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_overflow;

  logic          w_req;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pkt;

  // A change of bit 7 in either direction is exactly one request.
  assign w_req   = addr_in[7] ^ r_tog;
  assign w_empty = (r_count == 5'd0);
  assign w_full  = (r_count == DEPTH5);
  assign w_pop   = !w_empty && pkt_ready;
  // When full, a request is still taken if the head leaves this same cycle.
  assign w_push  = w_req && (!w_full || w_pop);
  assign w_pkt   = {1'b1, addr_in[3:0], addr_in[6:4], data_in[23:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tog      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      r_tog <= addr_in[7];
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 5'd1;
      end
      // A dropped request outranks a clear arriving in the same cycle.
      if (w_req && !w_push) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset; the empty gate below hides stale contents.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wr_ptr] <= w_pkt;
    end
  end

  assign pkt_valid = !w_empty;
  assign pkt_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign status    = {r_overflow, w_empty, w_full, r_count};

endmodule

// File: tb/tb_asp_request_packetizer.sv
// tb/tb_asp_request_packetizer.sv - randomized self-checking bench for asp_request_packetizer

module tb_asp_request_packetizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  addr_in = 8'h00;
  logic [31:0] data_in = 32'h0;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [7:0]  status;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q [$];
  bit          m_ovf = 1'b0;
  bit          m_prev = 1'b0;
  logic [31:0] got [$];
  logic [31:0] sent [$];

  asp_request_packetizer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .ovf_clear (ovf_clear),
    .status    (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_pkt(input logic [7:0] a, input logic [31:0] d);
    return {1'b1, a[3:0], a[6:4], d[23:0]};
  endfunction

  // Compare outputs against the queue model, then advance model and DUT one cycle.
  task automatic tick();
    int n;
    bit req, pop, drop;
    logic [31:0] exp_d;
    n = m_q.size();
    exp_d = (n > 0) ? m_q[0] : 32'd0;
    check("pkt_valid", 32'(pkt_valid), 32'(n > 0));
    check("pkt_data", pkt_data, exp_d);
    check("status", 32'(status), 32'({m_ovf, n == 0, n == DEPTH, 5'(n)}));
    if (reset_n && pkt_valid && pkt_ready) got.push_back(pkt_data);
    if (!reset_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_prev = 1'b0;
    end else begin
      req = (addr_in[7] != m_prev);
      pop = (n > 0) && pkt_ready;
      drop = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (req) begin
        if (n < DEPTH || pop) m_q.push_back(mk_pkt(addr_in, data_in));
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clear) m_ovf = 1'b0;
      m_prev = addr_in[7];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] dat);
    data_in = dat;
    addr_in = {~addr_in[7], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
  endtask

  initial begin
    logic [31:0] p1, newest;
    int nsent;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_status", 32'(status), 32'h40);
    check("reset_valid", 32'(pkt_valid), 32'h0);
    check("reset_data", pkt_data, 32'h0);

    // Single request
    pkt_ready = 1'b1;
    data_in = 32'h00ABCDEF;
    addr_in = 8'h85;
    tick();
    check("single_valid", 32'(pkt_valid), 32'h1);
    check("single_data", pkt_data, 32'hA8ABCDEF);
    tick();
    check("single_drained", 32'(pkt_valid), 32'h0);
    check("single_status", 32'(status), 32'h40);

    // Backpressure fill
    pkt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(32'(i));
      if (i == 1) p1 = mk_pkt(addr_in, data_in);
      tick();
    end
    check("fill_status", 32'(status), 32'h24);
    check("fill_head", pkt_data, p1);
    tick();
    check("fill_hold", pkt_data, p1);

    // Overflow, clear collision, clear alone
    send($urandom);
    tick();
    check("ovf_status", 32'(status), 32'hA4);
    check("ovf_head", pkt_data, p1);
    send($urandom);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("ovf_set_wins", 32'(status[7]), 32'h1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("ovf_cleared", 32'(status), 32'h24);

    // Full with simultaneous push and pop
    pkt_ready = 1'b1;
    send($urandom);
    newest = mk_pkt(addr_in, data_in);
    tick();
    check("fullpp_status", 32'(status), 32'h24);
    got.delete();
    for (int i = 0; i < 4; i++) tick();
    check("fullpp_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) check("fullpp_fourth", got[3], newest);
    check("drain_status", 32'(status), 32'h40);

    // Pointer wrap with random ready gating
    got.delete();
    sent.delete();
    nsent = 0;
    for (int c = 0; c < 300 && (nsent < 10 || m_q.size() > 0); c++) begin
      pkt_ready = 1'($urandom_range(0, 1));
      if (nsent < 10 && m_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        send($urandom);
        sent.push_back(mk_pkt(addr_in, data_in));
        nsent++;
      end
      tick();
    end
    check("wrap_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size() && i < sent.size(); i++) begin
      check($sformatf("wrap_pkt%0d", i), got[i], sent[i]);
    end

    // Mid-operation reset with toggle low
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send($urandom);
      tick();
    end
    check("pre_reset_status", 32'(status), 32'h03);
    addr_in[7] = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_reset_status", 32'(status), 32'h40);
    check("mid_reset_valid", 32'(pkt_valid), 32'h0);
    tick();
    check("no_spurious", 32'(status), 32'h40);

    // Reset held with toggle high fires one request after release
    addr_in = 8'h9C;
    data_in = 32'h12345678;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("hi_toggle_valid", 32'(pkt_valid), 32'h1);
    check("hi_toggle_data", pkt_data, 32'hE1345678);
    tick();
    check("hi_toggle_status", 32'(status), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
